// File: rtl/icu_fill_if.sv
// BIU read channel used by the icache line-fill engine: line request plus returning data beats.
interface icu_fill_if;
  logic        biu_req;
  logic [31:0] biu_addr;
  logic        biu_ack;
  logic [31:0] biu_data;
  logic        biu_data_vld;
  logic        biu_err;

  modport master (output biu_req, biu_addr,
                  input  biu_ack, biu_data, biu_data_vld, biu_err);
  modport slave  (input  biu_req, biu_addr,
                  output biu_ack, biu_data, biu_data_vld, biu_err);
endinterface

// File: rtl/icu_fill.sv
// Icache line-fill engine: requests a line from the BIU and writes each 32-bit beat into the data RAM.
// Optional macro ICU_CRITICAL_WORD_FIRST_EN: request the missing word first and wrap beats around the line.
module icu_fill #(
  parameter int IC_MSB     = 13,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              miss_req,
  input  logic [31:0]       miss_addr,
  input  logic              icu_flush,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              fill_err,
  icu_fill_if.master        biu,
  output logic [31:0]       icu_din,
  output logic [1:0]        icu_ram_we,
  output logic [IC_MSB-3:0] icu_addr,
  output logic              icu_ram_en
);

  localparam int WIDX = $clog2(LINE_WORDS);
  localparam int EW   = IC_MSB - 2;
  localparam logic [31:0]   LINE_MASK  = ~((32'(LINE_WORDS) * 32'd4) - 32'd1);
  localparam logic [EW-1:0] ENTRY_MASK = EW'((LINE_WORDS / 2) - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_FILL, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [1:0]    we;
    logic [EW-1:0] addr;
    logic [31:0]   din;
  } ram_wr_t;

  state_t          state, state_nxt;
  logic [WIDX-1:0] cnt, start_word, widx;
  logic [EW-1:0]   line_entry;
  logic [31:0]     addr_q;
  logic            drop, err_q;
  ram_wr_t         wr;

  logic beat, bad, last, beat_end, accept, wr_fire;

  assign beat     = biu.biu_data_vld;
  assign bad      = beat & biu.biu_err;
  assign last     = (cnt == WIDX'(LINE_WORDS - 1));
  assign beat_end = beat & (biu.biu_err | last);
  assign accept   = (state == S_IDLE) & miss_req;
  assign widx     = start_word + cnt;
  assign wr_fire  = (state == S_FILL) & ~drop & beat & ~biu.biu_err & ~icu_flush;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (miss_req) state_nxt = S_REQ;
      // An ack arriving with the flush means beats are coming; they must still be drained.
      S_REQ:   if (biu.biu_ack)    state_nxt = icu_flush ? S_DRAIN : S_FILL;
               else if (icu_flush) state_nxt = S_IDLE;
      S_FILL:  if (icu_flush)      state_nxt = beat_end ? S_IDLE : S_DRAIN;
               else if (bad)       state_nxt = S_IDLE;
               else if (beat && last) state_nxt = S_DONE;
      S_DRAIN: if (beat_end) state_nxt = S_IDLE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    fill_busy   = (state != S_IDLE);
    biu.biu_req = (state == S_REQ);
    fill_done   = (state == S_DONE);
    fill_err    = err_q;
  end

  assign biu.biu_addr = addr_q;
  assign icu_din      = wr.din;
  assign icu_ram_we   = wr.we;
  assign icu_addr     = wr.addr;
  assign icu_ram_en   = |wr.we;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      addr_q     <= '0;
      line_entry <= '0;
      start_word <= '0;
      cnt        <= '0;
      drop       <= 1'b0;
      err_q      <= 1'b0;
      wr         <= '0;
    end else begin
      if (accept) begin
        line_entry <= miss_addr[IC_MSB:3] & ~ENTRY_MASK;
`ifdef ICU_CRITICAL_WORD_FIRST_EN
        addr_q     <= miss_addr & ~32'h3;
        start_word <= miss_addr[WIDX+1:2];
`else
        addr_q     <= miss_addr & LINE_MASK;
        start_word <= '0;
`endif
      end

      // Flushed beats still count so DRAIN knows when the BIU transfer has ended.
      if (state == S_IDLE || state_nxt == S_IDLE) cnt <= '0;
      else if (beat && (state == S_FILL || state == S_DRAIN)) cnt <= cnt + WIDX'(1);

      if (state_nxt == S_IDLE) drop <= 1'b0;
      else if (icu_flush && (state == S_FILL || (state == S_REQ && biu.biu_ack))) drop <= 1'b1;

      err_q <= (state == S_FILL) & bad & ~icu_flush;

      wr.we <= wr_fire ? (widx[0] ? 2'b01 : 2'b10) : 2'b00;
      if (wr_fire) begin
        wr.addr <= line_entry + EW'(widx >> 1);
        wr.din  <= biu.biu_data;
      end
    end
  end

endmodule

// File: tb/tb_icu_fill.sv
// Directed bench for icu_fill: reset, ordered/wrapped fills, error, flush and back-pressure cases.
module tb_icu_fill;
  logic        clk = 1'b0;
  logic        reset_l;
  logic        miss_req, icu_flush;
  logic [31:0] miss_addr;
  logic        fill_busy, fill_done, fill_err;
  logic [31:0] icu_din;
  logic [1:0]  icu_ram_we;
  logic [10:0] icu_addr;
  logic        icu_ram_en;

  icu_fill_if biu();

  icu_fill #(.IC_MSB(13), .LINE_WORDS(4)) dut (
    .clk(clk), .reset_l(reset_l), .miss_req(miss_req), .miss_addr(miss_addr),
    .icu_flush(icu_flush), .fill_busy(fill_busy), .fill_done(fill_done),
    .fill_err(fill_err), .biu(biu), .icu_din(icu_din), .icu_ram_we(icu_ram_we),
    .icu_addr(icu_addr), .icu_ram_en(icu_ram_en)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Write log {fill_done, icu_addr, we, din} plus event counters, sampled on the falling edge.
  logic [45:0] wq[$];
  int rd = 0;
  int done_cnt = 0, err_cnt = 0, req_cycles = 0, req_rise = 0, en_bad = 0;
  logic req_prev = 1'b0;

  always @(negedge clk) begin
    if (icu_ram_we != 2'b00) wq.push_back({fill_done, icu_addr, icu_ram_we, icu_din});
    if (fill_done) done_cnt <= done_cnt + 1;
    if (fill_err)  err_cnt  <= err_cnt + 1;
    if (icu_ram_en !== (icu_ram_we != 2'b00)) en_bad <= en_bad + 1;
    if (biu.biu_req) req_cycles <= req_cycles + 1;
    if (biu.biu_req && !req_prev) req_rise <= req_rise + 1;
    req_prev <= biu.biu_req;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input logic [45:0] exp);
    logic [45:0] o;
    o = (rd < wq.size()) ? wq[rd] : '1;
    rd++;
    check(tag, 64'(o), 64'(exp));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Raise a miss, keep the request pending for nreq cycles, ack on the last; returns in FILL.
  task automatic issue(input logic [31:0] a, input int nreq, input logic hold);
    miss_req = 1'b1; miss_addr = a;
    tick();
    miss_req = hold;
    repeat (nreq - 1) tick();
    biu.biu_ack = 1'b1;
    tick();
    biu.biu_ack = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic e, input logic f);
    biu.biu_data_vld = 1'b1; biu.biu_data = d; biu.biu_err = e; icu_flush = f;
    tick();
    biu.biu_data_vld = 1'b0; biu.biu_err = 1'b0; icu_flush = 1'b0;
  endtask

  int b_done, b_err, b_req, b_rise;

  task automatic snap();
    b_done = done_cnt; b_err = err_cnt; b_req = req_cycles; b_rise = req_rise;
  endtask

  initial begin
    reset_l = 1'b0; miss_req = 1'b0; miss_addr = '0; icu_flush = 1'b0;
    biu.biu_ack = 1'b0; biu.biu_data = '0; biu.biu_data_vld = 1'b0; biu.biu_err = 1'b0;
    tick(); tick();
    check("rst_ctl", 64'({fill_busy, fill_done, fill_err, biu.biu_req, icu_ram_en, icu_ram_we}), 64'(0));
    check("rst_biu_addr", 64'(biu.biu_addr), 64'(0));
    check("rst_ram", 64'({icu_addr, icu_din}), 64'(0));
    reset_l = 1'b1;
    tick();

    // Basic fill from 0x1234.
    snap();
    issue(32'h0000_1234, 1, 1'b0);
    check("basic_req_off", 64'(biu.biu_req), 64'(0));
    check("basic_busy", 64'(fill_busy), 64'(1));
    check("basic_req_cycles", 64'(req_cycles - b_req), 64'(1));
`ifdef ICU_CRITICAL_WORD_FIRST_EN
    check("basic_biu_addr", 64'(biu.biu_addr), 64'h1234);
`else
    check("basic_biu_addr", 64'(biu.biu_addr), 64'h1230);
`endif
    beat(32'hA0, 1'b0, 1'b0);
    beat(32'hA1, 1'b0, 1'b0);
    beat(32'hA2, 1'b0, 1'b0);
    beat(32'hA3, 1'b0, 1'b0);
    check("basic_done_pulse", 64'(fill_done), 64'(1));
    tick();
    check("basic_idle", 64'({fill_busy, fill_done}), 64'(0));
`ifdef ICU_CRITICAL_WORD_FIRST_EN
    check_wr("basic_w0", {1'b0, 11'h246, 2'b01, 32'hA0});
    check_wr("basic_w1", {1'b0, 11'h247, 2'b10, 32'hA1});
    check_wr("basic_w2", {1'b0, 11'h247, 2'b01, 32'hA2});
    check_wr("basic_w3", {1'b1, 11'h246, 2'b10, 32'hA3});
`else
    check_wr("basic_w0", {1'b0, 11'h246, 2'b10, 32'hA0});
    check_wr("basic_w1", {1'b0, 11'h246, 2'b01, 32'hA1});
    check_wr("basic_w2", {1'b0, 11'h247, 2'b10, 32'hA2});
    check_wr("basic_w3", {1'b1, 11'h247, 2'b01, 32'hA3});
`endif
    check("basic_nwr", 64'(wq.size() - rd), 64'(0));
    check("basic_done_cnt", 64'(done_cnt - b_done), 64'(1));

    // Miss on word 2 of the line at 0x1230.
    issue(32'h0000_1238, 1, 1'b0);
`ifdef ICU_CRITICAL_WORD_FIRST_EN
    check("cwf_biu_addr", 64'(biu.biu_addr), 64'h1238);
`else
    check("cwf_biu_addr", 64'(biu.biu_addr), 64'h1230);
`endif
    beat(32'hB0, 1'b0, 1'b0);
    beat(32'hB1, 1'b0, 1'b0);
    beat(32'hB2, 1'b0, 1'b0);
    beat(32'hB3, 1'b0, 1'b0);
    tick();
`ifdef ICU_CRITICAL_WORD_FIRST_EN
    check_wr("cwf_w0", {1'b0, 11'h247, 2'b10, 32'hB0});
    check_wr("cwf_w1", {1'b0, 11'h247, 2'b01, 32'hB1});
    check_wr("cwf_w2", {1'b0, 11'h246, 2'b10, 32'hB2});
    check_wr("cwf_w3", {1'b1, 11'h246, 2'b01, 32'hB3});
`else
    check_wr("cwf_w0", {1'b0, 11'h246, 2'b10, 32'hB0});
    check_wr("cwf_w1", {1'b0, 11'h246, 2'b01, 32'hB1});
    check_wr("cwf_w2", {1'b0, 11'h247, 2'b10, 32'hB2});
    check_wr("cwf_w3", {1'b1, 11'h247, 2'b01, 32'hB3});
`endif

    // BIU error on the third beat.
    snap();
    issue(32'h0000_2000, 1, 1'b0);
    beat(32'hC0, 1'b0, 1'b0);
    beat(32'hC1, 1'b0, 1'b0);
    beat(32'hC2, 1'b1, 1'b0);
    check("err_pulse", 64'(fill_err), 64'(1));
    check("err_busy", 64'(fill_busy), 64'(0));
    tick();
    check("err_pulse_end", 64'(fill_err), 64'(0));
    check_wr("err_w0", {1'b0, 11'h400, 2'b10, 32'hC0});
    check_wr("err_w1", {1'b0, 11'h400, 2'b01, 32'hC1});
    check("err_nwr", 64'(wq.size() - rd), 64'(0));
    check("err_cnts", 64'({err_cnt - b_err, done_cnt - b_done}), {32'd1, 32'd0});

    // Flush during the second beat: the rest drain with no writes.
    snap();
    issue(32'h0000_3000, 1, 1'b0);
    beat(32'hD0, 1'b0, 1'b0);
    beat(32'hD1, 1'b0, 1'b1);
    check("flush_busy1", 64'(fill_busy), 64'(1));
    beat(32'hD2, 1'b0, 1'b0);
    check("flush_busy2", 64'(fill_busy), 64'(1));
    beat(32'hD3, 1'b0, 1'b0);
    check("flush_idle", 64'(fill_busy), 64'(0));
    tick();
    check_wr("flush_w0", {1'b0, 11'h600, 2'b10, 32'hD0});
    check("flush_nwr", 64'(wq.size() - rd), 64'(0));
    check("flush_cnts", 64'({err_cnt - b_err, done_cnt - b_done}), 64'(0));

    // Flush coinciding with the last beat.
    snap();
    issue(32'h0000_3000, 1, 1'b0);
    beat(32'hE0, 1'b0, 1'b0);
    beat(32'hE1, 1'b0, 1'b0);
    beat(32'hE2, 1'b0, 1'b0);
    beat(32'hE3, 1'b0, 1'b1);
    check("flast_idle", 64'({fill_busy, fill_done}), 64'(0));
    tick();
    check_wr("flast_w0", {1'b0, 11'h600, 2'b10, 32'hE0});
    check_wr("flast_w1", {1'b0, 11'h600, 2'b01, 32'hE1});
    check_wr("flast_w2", {1'b0, 11'h601, 2'b10, 32'hE2});
    check("flast_nwr", 64'(wq.size() - rd), 64'(0));
    check("flast_done", 64'(done_cnt - b_done), 64'(0));

    // Flush together with an error beat.
    snap();
    issue(32'h0000_3000, 1, 1'b0);
    beat(32'hF0, 1'b1, 1'b1);
    check("ferr_state", 64'({fill_err, fill_busy}), 64'(0));
    tick();
    check("ferr_cnt", 64'(err_cnt - b_err), 64'(0));
    check("ferr_nwr", 64'(wq.size() - rd), 64'(0));

    // Ack delayed five cycles with miss_req held throughout.
    snap();
    issue(32'h0000_1234, 5, 1'b1);
    check("bp_req_cycles", 64'(req_cycles - b_req), 64'(5));
    beat(32'h10, 1'b0, 1'b0);
    beat(32'h11, 1'b0, 1'b0);
    beat(32'h12, 1'b0, 1'b0);
    miss_req = 1'b0;
    beat(32'h13, 1'b0, 1'b0);
    tick();
    check("bp_idle", 64'(fill_busy), 64'(0));
    tick();
    check("bp_one_req", 64'(req_rise - b_rise), 64'(1));
    check("bp_nwr", 64'(wq.size() - rd), 64'(4));
    check("bp_done", 64'(done_cnt - b_done), 64'(1));
    rd = wq.size();

    // Reset in the middle of a fill.
    snap();
    issue(32'h0000_1234, 1, 1'b0);
    beat(32'h20, 1'b0, 1'b0);
    beat(32'h21, 1'b0, 1'b0);
    #2 reset_l = 1'b0;
    #1;
    check("mrst_ctl", 64'({fill_busy, fill_done, fill_err, biu.biu_req, icu_ram_en, icu_ram_we}), 64'(0));
    check("mrst_biu_addr", 64'(biu.biu_addr), 64'(0));
    check("mrst_ram", 64'({icu_addr, icu_din}), 64'(0));
    tick();
    beat(32'h22, 1'b0, 1'b0);
    reset_l = 1'b1;
    beat(32'h23, 1'b0, 1'b0);
    tick(); tick();
    check("mrst_busy", 64'(fill_busy), 64'(0));
    check("mrst_nwr", 64'(wq.size() - rd), 64'(2));
    check("mrst_cnts", 64'({err_cnt - b_err, done_cnt - b_done}), 64'(0));
    check("ram_en_track", 64'(en_bad), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
